// File: rtl/ahfp_pkg.sv
// Shared FP32 definitions for the add/sub client blocks.
//   FP_W, FP_SIGN_BIT : FP32 word width and sign-bit position
//   fp32_t            : FP32 word type
//   FP32_ONE/ZERO     : handy FP32 constants
//   fp32_negate_if    : conditionally flip the sign bit (turns a-b into a+(-b))
package ahfp_pkg;

    localparam int unsigned FP_W        = 32;
    localparam int unsigned FP_SIGN_BIT = 31;

    typedef logic [FP_W-1:0] fp32_t;

    localparam fp32_t FP32_ONE  = 32'h3F80_0000;
    localparam fp32_t FP32_ZERO = 32'h0000_0000;

    // Pure sign-bit manipulation: NaN/Inf payloads are left untouched.
    function automatic fp32_t fp32_negate_if(input fp32_t x, input logic neg);
        fp32_t r;
        r              = x;
        r[FP_SIGN_BIT] = x[FP_SIGN_BIT] ^ neg;
        return r;
    endfunction

endpackage

// File: rtl/ahfp_result_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : push wr_data (caller guarantees space, or a same-cycle pop when full)
//   rd_en      : pop the head entry (ignored while empty)
//   rd_data    : head entry, forced to 0 while empty
//   empty/full : status flags
//   count      : number of stored entries, $clog2(DEPTH)+1 bits
module ahfp_result_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_rd;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign count = count_q;
    assign do_rd = rd_en & ~empty;

    // Writing while full is only safe with a pop: the overwritten slot is the head being read.
    always_comb begin
        count_d = count_q;
        unique case ({wr_en, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset; the output is masked while empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/ahfp_add_sub_issue.sv
// Client-side issue/collect block for a fixed-latency, non-stallable FP32 add/sub unit.
// Operands are registered onto fp_dataa/fp_datab (b sign-flipped for subtraction), a valid
// shift register tracks in-flight ops, and results land in a FWFT FIFO. Credits (in-flight +
// buffered <= DEPTH) guarantee the FIFO can always absorb every result.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand stream handshake; in_a, in_b, in_sub, in_tag payload
//   fp_dataa/fp_datab     : registered operands to the add/sub unit
//   fp_result             : unit result, valid LATENCY cycles after the operands
//   out_valid/out_ready   : result stream handshake; out_data, out_tag payload
// Build option: define AHFP_ISSUE_TAG_EN to carry in_tag alongside each op to out_tag;
// otherwise in_tag is ignored and out_tag is tied to 0.
module ahfp_add_sub_issue
    import ahfp_pkg::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_a,
    input  logic [FP_W-1:0]  in_b,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic [FP_W-1:0]  fp_dataa,
    output logic [FP_W-1:0]  fp_datab,
    input  logic [FP_W-1:0]  fp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_MAX = DEPTH[CNT_W:0];

`ifdef AHFP_ISSUE_TAG_EN
    localparam int unsigned ENTRY_W = FP_W + TAG_W;
`else
    localparam int unsigned ENTRY_W = FP_W;
`endif

    logic [LATENCY:0]   vld_q;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W:0]     credit_used;
    logic               issue, retire, pop;
    logic               fifo_empty, fifo_full;
    logic [ENTRY_W-1:0] fifo_wr_data, fifo_rd_data;
    fp32_t              dataa_q, datab_q;

    // Credit check depends on registers only, so in_ready has no path from in_valid/out_ready.
    assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt};
    assign in_ready    = (credit_used < CREDIT_MAX);
    assign issue       = in_valid & in_ready;
    assign retire      = vld_q[LATENCY];
    assign pop         = out_valid & out_ready;

    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue, retire})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q      <= '0;
            inflight_q <= '0;
            dataa_q    <= FP32_ZERO;
            datab_q    <= FP32_ZERO;
        end else begin
            vld_q      <= {vld_q[LATENCY-1:0], issue};
            inflight_q <= inflight_d;
            if (issue) begin
                dataa_q <= in_a;
                datab_q <= fp32_negate_if(in_b, in_sub);
            end
        end
    end

    assign fp_dataa = dataa_q;
    assign fp_datab = datab_q;

`ifdef AHFP_ISSUE_TAG_EN
    // Tags ride a pipe aligned with vld_q so tag_q[LATENCY] pairs with fp_result.
    logic [LATENCY:0][TAG_W-1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= {tag_q[LATENCY-1:0], in_tag};
        end
    end

    assign fifo_wr_data = {tag_q[LATENCY], fp_result};
    assign out_tag      = fifo_rd_data[FP_W +: TAG_W];
`else
    logic unused_tag;
    assign unused_tag   = ^in_tag;
    assign fifo_wr_data = fp_result;
    assign out_tag      = '0;
`endif

    ahfp_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (retire),
        .wr_data (fifo_wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_cnt)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_rd_data[FP_W-1:0];

`ifndef SYNTHESIS
    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) retire |-> (!fifo_full || pop));
    a_credit_bound: assert property (
        @(posedge clk) disable iff (!rst_n) credit_used <= CREDIT_MAX);
`endif

endmodule

// File: tb/tb_ahfp_add_sub_issue.sv
module tb_ahfp_add_sub_issue;

    localparam int unsigned LATENCY = 4;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned TAG_W   = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a, in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fp_dataa, fp_datab, fp_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    int checks   = 0;
    int failures = 0;

    ahfp_add_sub_issue #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH),
        .TAG_W   (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_tag    (in_tag),
        .fp_dataa  (fp_dataa),
        .fp_datab  (fp_datab),
        .fp_result (fp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normal numbers and zero only; enough for the directed operands used here.
    function automatic real f32_to_real(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:23] == 8'd0 || x[30:23] == 8'hFF) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] int_to_f32(input int i);
        return real_to_f32($itor(i));
    endfunction

    // Behavioural stand-in for the fixed-latency add/sub unit.
    logic [31:0] unit_pipe [LATENCY];
    always @(posedge clk) begin
        unit_pipe[0] <= real_to_f32(f32_to_real(fp_dataa) + f32_to_real(fp_datab));
        for (int i = 1; i < LATENCY; i++) unit_pipe[i] <= unit_pipe[i-1];
    end
    assign fp_result = unit_pipe[LATENCY-1];

    // Collect every accepted result.
    logic [31:0]      rx_data [$];
    logic [TAG_W-1:0] rx_tag  [$];
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            rx_data.push_back(out_data);
            rx_tag.push_back(out_tag);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op and hold it until accepted; leaves in_valid low at posedge+1.
    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [TAG_W-1:0] tag, output int waits);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_tag   = tag;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                $display("FAIL push_op_timeout: got stalled expected accept");
                failures++;
                break;
            end
            step();
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input string name, input int n);
        int budget;
        budget = 0;
        while (rx_data.size() < n && budget < 200) begin
            step();
            budget++;
        end
        check(name, rx_data.size(), n);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] exp_datab;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs [6];
    logic [31:0] exp_q [$];

    initial begin
        int lat;
        int waits;
        int drops;
        int accepted;
        int viol;
        bit rand_run;

        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4000_0000, 32'h4040_0000};
        vecs[1] = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 32'h4000_0000};
        vecs[2] = '{32'h40A0_0000, 32'hC000_0000, 1'b1, 32'h4000_0000, 32'h40E0_0000};
        vecs[3] = '{32'hBF80_0000, 32'hBF80_0000, 1'b0, 32'hBF80_0000, 32'hC000_0000};
        vecs[4] = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'hBF80_0000, 32'h0000_0000};
        vecs[5] = '{32'h4120_0000, 32'h3F00_0000, 1'b0, 32'h3F00_0000, 32'h4128_0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset / idle state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_fp_dataa", fp_dataa, 0);
        check("rst_fp_datab", fp_datab, 0);
        check("rst_out_tag", out_tag, 0);
        step();

        // Single ops with exact latency
        out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            in_valid = 1'b1;
            in_a     = vecs[v].a;
            in_b     = vecs[v].b;
            in_sub   = vecs[v].sub;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_fp_dataa", v), fp_dataa, vecs[v].a);
            check($sformatf("vec%0d_fp_datab", v), fp_datab, vecs[v].exp_datab);
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("vec%0d_latency", v), lat, LATENCY + 2);
            check($sformatf("vec%0d_out_data", v), out_data, vecs[v].exp_result);
            step();
            step();
        end

        // Back-to-back 16 ops, out_ready=1
        rx_data.delete();
        rx_tag.delete();
        exp_q.delete();
        drops = 0;
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            a = int_to_f32(i + 1);
            exp_q.push_back(int_to_f32((i % 2 == 1) ? (i + 1 - 2) : (i + 1 + 2)));
            push_op(a, 32'h4000_0000, (i % 2 == 1), '0, waits);
            drops += waits;
        end
        check("b2b_in_ready_drops", drops, 0);
        wait_rx("b2b_count", 16);
        for (int i = 0; i < 16 && i < rx_data.size(); i++)
            check($sformatf("b2b_data%0d", i), rx_data[i], exp_q[i]);

        // Backpressure: fill credits with out_ready low
        repeat (2) step();
        rx_data.delete();
        rx_tag.delete();
        exp_q.delete();
        out_ready = 1'b0;
        accepted  = 0;
        in_valid  = 1'b1;
        in_b      = 32'h3F80_0000;
        in_sub    = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_a = int_to_f32(accepted + 20);
            @(negedge clk);
            if (!in_ready) break;
            exp_q.push_back(int_to_f32(accepted + 21));
            accepted++;
            step();
        end
        in_valid = 1'b0;
        check("bp_accepted", accepted, DEPTH);
        check("bp_in_ready_low", in_ready, 0);
        repeat (LATENCY + 3) step();
        @(negedge clk);
        check("bp_in_ready_still_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_before_pop", in_ready, 0);
        @(negedge clk);
        check("bp_in_ready_after_pop", in_ready, 1);
        wait_rx("bp_count", DEPTH);
        for (int i = 0; i < DEPTH && i < rx_data.size(); i++)
            check($sformatf("bp_data%0d", i), rx_data[i], exp_q[i]);

        // Reset with three ops in flight
        repeat (2) step();
        for (int i = 0; i < 3; i++) push_op(int_to_f32(i + 5), 32'h3F80_0000, 1'b0, '0, waits);
        #2;
        rst_n = 1'b0;
        repeat (2) step();
        #2;
        rst_n = 1'b1;
        rx_data.delete();
        rx_tag.delete();
        @(negedge clk);
        check("rstmid_in_ready", in_ready, 1);
        check("rstmid_fp_dataa", fp_dataa, 0);
        viol = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) viol++;
        end
        check("rstmid_no_out_valid", viol, 0);
        step();
        push_op(32'h4040_0000, 32'h4080_0000, 1'b1, '0, waits);
        wait_rx("rstmid_next_count", 1);
        if (rx_data.size() > 0) check("rstmid_next_data", rx_data[0], 32'hBF80_0000);

`ifdef AHFP_ISSUE_TAG_EN
        // Tags with random out_ready
        repeat (2) step();
        rx_data.delete();
        rx_tag.delete();
        rand_run = 1'b1;
        fork
            while (rand_run) begin
                step();
                if (rand_run) out_ready = ($urandom_range(0, 1) == 1);
            end
        join_none
        for (int i = 0; i < 8; i++)
            push_op(int_to_f32(i + 1), 32'h3F80_0000, 1'b0, TAG_W'(i), waits);
        repeat (20) step();
        rand_run = 1'b0;
        step();
        #1;
        out_ready = 1'b1;
        wait_rx("tag_count", 8);
        for (int i = 0; i < 8 && i < rx_data.size(); i++) begin
            check($sformatf("tag_data%0d", i), rx_data[i], int_to_f32(i + 2));
            check($sformatf("tag_tag%0d", i), rx_tag[i], i);
        end
`else
        rand_run = 1'b0;
        check("notag_out_tag", out_tag, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
